// File: rtl/apb_slave_mem_if.sv
// APB bus bundle between the master bridge and the byte-wide memory completer.
interface apb_slave_mem_if;
  logic       PSEL;
  logic       PENABLE;
  logic       PWRITE;
  logic [8:0] PADDR;
  logic [7:0] PWDATA;
  logic [7:0] PRDATA;
  logic       PREADY;
  logic       PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_slave_mem.sv
// APB completer with a byte-wide register file, programmable wait states and
// PSLVERR on out-of-range addresses.
//
// Handshake: a setup phase is an edge with PSEL=1, PENABLE=0; the transfer
// completes on the edge where PSEL, PENABLE and PREADY are all 1. Dropping
// PSEL or PENABLE during the access phase abandons the transfer.
module apb_slave_mem #(
  parameter int WAIT_STATES = 0,
  parameter int MEM_DEPTH   = 256
) (
  input  logic            PCLK,
  input  logic            PRESET,
  apb_slave_mem_if.slave  apb,
  output logic            dbg_state
);

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  localparam logic [3:0] WS_L    = 4'(WAIT_STATES);
  localparam logic [9:0] DEPTH_L = 10'(MEM_DEPTH);

  state_t     state;
  logic [3:0] cnt;
  logic [7:0] addr_q;
  logic       wr_q;
  logic [7:0] wdata_q;
  logic [7:0] rdata_q;
  logic       err_q;
  logic [7:0] mem [0:255];

  logic setup_hit;
  logic addr_err;
  assign setup_hit = apb.PSEL && !apb.PENABLE;
  assign addr_err  = ({1'b0, apb.PADDR} >= DEPTH_L);

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < 256; i++) mem[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (setup_hit) begin
            state   <= ACCESS;
            addr_q  <= apb.PADDR[7:0];
            wr_q    <= apb.PWRITE;
            wdata_q <= apb.PWDATA;
            err_q   <= addr_err;
            // Range check happens before indexing so 256..511 never alias.
            rdata_q <= addr_err ? 8'h00 : mem[apb.PADDR[7:0]];
            cnt     <= '0;
          end
        end
        ACCESS: begin
          if (apb.PSEL && apb.PENABLE) begin
            if (cnt == WS_L) begin
              state <= IDLE;
              if (wr_q && !err_q) mem[addr_q] <= wdata_q;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs depend only on registered state, never on PSEL/PENABLE directly.
  assign apb.PREADY  = (state == ACCESS) && (cnt == WS_L);
  assign apb.PSLVERR = apb.PREADY && err_q;
  assign apb.PRDATA  = (apb.PREADY && !wr_q && !err_q) ? rdata_q : 8'h00;
  assign dbg_state   = (state == ACCESS);

endmodule
